// File: rtl/fifo_wr_arbiter.sv
// Two-producer write-port arbiter for a single fifo: round-robin grants with bounded bursts.
// Define FIFO_ARB_FIXED_PRIO_EN to make producer 0 win every arbitration point instead.
module fifo_wr_arbiter #(
   parameter int B         = 3,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic [B-1:0] data0,
   output logic         ack0,
   input  logic         req1,
   input  logic [B-1:0] data1,
   output logic         ack1,
   input  logic         full,
   output logic         fifo_wr,
   output logic [B-1:0] fifo_w_data,
   output logic [1:0]   grant
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic       own_req, oth_req;
   logic       win_vld, win;
   logic       rearb;
`ifndef FIFO_ARB_FIXED_PRIO_EN
   logic       last, last_n;
`endif

   // State register: grant is the state encoding itself, so it is registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 8'd0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
         last  <= 1'b1;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
`ifndef FIFO_ARB_FIXED_PRIO_EN
         last  <= last_n;
`endif
      end
   end

   // Winner of an arbitration point evaluated against the current requests.
   always_comb begin
      own_req = (state == OWN1) ? req1 : req0;
      oth_req = (state == OWN1) ? req0 : req1;
      win_vld = req0 | req1;
`ifdef FIFO_ARB_FIXED_PRIO_EN
      win = ~req0;
`else
      if (state == IDLE)
         win = (req0 & req1) ? ~last : ~req0;
      else if (oth_req)
         win = (state == OWN0);
      else
         win = (state == OWN1);
`endif
   end

   // Next state: stalls on full freeze everything; bursts end on the last beat or a dropped req.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rearb   = 1'b0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      last_n  = last;
`endif
      if (state == IDLE) begin
         rearb = 1'b1;
      end else if (own_req & ~full) begin
         if (cnt == LAST_BEAT)
            rearb = 1'b1;
         else
            cnt_n = cnt + 8'd1;
      end else if (~own_req) begin
         rearb = 1'b1;
      end

      if (rearb) begin
         cnt_n = 8'd0;
         if (win_vld) begin
            state_n = win ? OWN1 : OWN0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            last_n  = win;
`endif
         end else begin
            state_n = IDLE;
         end
      end
   end

   always_comb begin
      grant       = state;
      ack0        = state[0] & req0 & ~full;
      ack1        = state[1] & req1 & ~full;
      fifo_wr     = ack0 | ack1;
      fifo_w_data = state[1] ? data1 : data0;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one `fifo` instance (parameters B, W) between two independent producers.
- Round-robin arbitration with a bounded burst length per grant.
- Applies `full` back-pressure to the granted producer through a valid/ready handshake.
- Sits between the producer logic (switch/button front-end, or future datapath sources) and the `fifo` wr/w_data/full pins. The read side of the fifo is untouched.

Parameters:
- B, 3: data word width; must match the fifo's B.
- MAX_BURST, 4: maximum writes per grant, range 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  producer 0 has a valid word on data0
- data0  in  B  producer 0 write data
- ack0  out  1  producer 0 word accepted this cycle (combinational)
- req1  in  1  producer 1 has a valid word on data1
- data1  in  B  producer 1 write data
- ack1  out  1  producer 1 word accepted this cycle (combinational)
- full  in  1  fifo full flag
- fifo_wr  out  1  fifo write strobe (combinational)
- fifo_w_data  out  B  fifo write data (combinational mux)
- grant  out  2  one-hot registered owner: 01=producer0, 10=producer1, 00=idle

Behaviour:
- Interface: one clock, `clk`; reset `reset` is synchronous and active-high. Clock and reset polarity and synchronicity are fixed.
- Handshake: a transfer occurs in a cycle when reqX=1 and ackX=1. The producer must hold reqX and dataX stable until ackX. It may change both the cycle after ackX.
- Write condition: ackX = grant[X] & reqX & ~full.
  - fifo_wr = ack0 | ack1.
  - fifo_w_data = data1 when grant[1], otherwise data0.
  - The arbiter never writes while full=1.
- State:
  - FSM states: IDLE (grant=00), OWN0 (01), OWN1 (10).
  - Burst counter cnt, 8 bits.
  - Round-robin pointer last: the last producer granted.
- Reset values: state=IDLE, grant=00, cnt=0, last=1 so producer 0 wins first. Consequently ack0=ack1=fifo_wr=0 and fifo_w_data=data0.
- IDLE:
  - If any req is high, go to OWN of the winner, with cnt=0 and last updated.
  - Winner: the sole requester, or the producer other than `last` when both request.
  - Latency: req sampled high in IDLE gives ack no earlier than the next cycle.
- OWNx, a transfer occurs:
  - cnt increments.
  - If cnt was MAX_BURST-1, the burst is done and the block re-arbitrates.
- OWNx, reqX=0: re-arbitrate immediately at this edge.
- OWNx, full=1 and reqX=1: stall.
  - No write, grant held, cnt frozen.
  - Full stalls do not count toward the burst.
- Re-arbitration from OWNx:
  - If the other producer requests: next state is its OWN, cnt=0. No dead cycle between owners.
  - Else if reqX is still high (burst exhausted): OWNx again, cnt=0.
  - Else: IDLE.
- Simultaneous events:
  - A burst-ending write and the other producer's request in the same cycle hand over at that edge.
  - Both reqs rising together in IDLE: decided by `last`.
- Reset mid-burst: the write in the reset cycle still occurs if ack was high. This is combinational from the pre-reset state. The next cycle is IDLE with cnt=0, last=1.
- MAX_BURST=1: ownership alternates every write while both producers request.

Optional Feature:
- Macro: FIFO_ARB_FIXED_PRIO_EN.
- Defined:
  - Every arbitration point, including burst exhaustion, grants producer 0 whenever req0=1.
  - `last` is not used.
  - Producer 1 can starve. This is accepted and is the intended behaviour.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then req0=1 with words 5,2,7, full=0, MAX_BURST=4 -> grant=01 one cycle later; ack0/fifo_wr high 3 consecutive cycles; fifo_w_data 5,2,7; then grant=00.
- After reset, req0=req1=1 continuously -> producer 0 first; fifo_wr every cycle; ownership 01 for 4 writes, 10 for 4 writes, 01 ...; no idle cycle at handover.
- Producer 0 mid-burst after write 2, full=1 for 3 cycles -> fifo_wr=0, ack0=0, grant=01 held; after full=0, exactly 2 more writes before handover.
- Producer 1 owning, req1 drops after 1 write, req0=1 -> grant=01 the next cycle; ack0 that cycle.
- reset asserted for 1 cycle mid-burst of producer 1 -> next cycle grant=00, fifo_wr=0; with both reqs high, producer 0 granted first.
- With FIFO_ARB_FIXED_PRIO_EN, both reqs continuous for 20 cycles -> grant stays 01; ack1 never asserted; 20 writes of data0.
